// File: rtl/wb_pkg.sv
// wb_pkg: shared owner/state encoding, Wishbone CTI codes and a constant clog2 helper
package wb_pkg;
  typedef enum logic [1:0] {OWN_NONE = 2'b00, OWN_I = 2'b01, OWN_D = 2'b10} owner_t;
  localparam logic [2:0] CLASSIC = 3'b000;
  localparam logic [2:0] INCR = 3'b010;
  localparam logic [2:0] EOB = 3'b111;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/wb_timeout_wdt.sv
// wb_timeout_wdt: counts unacknowledged strobe cycles and fires when TIMEOUT is reached
module wb_timeout_wdt
  import wb_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic active,
  input  logic ack,
  input  logic err,
  input  logic clear,
  output logic fire
);
  localparam int CW = clog2(TIMEOUT + 1) > 0 ? clog2(TIMEOUT + 1) : 1;
  logic [CW-1:0] cnt;
  // a slave response on the limit cycle wins over the forced error
  assign fire = (TIMEOUT > 0) && active && !ack && !err && cnt == CW'(TIMEOUT);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt <= '0;
    else cnt <= (clear || fire || !active || ack || err) ? '0 : (&cnt) ? cnt : cnt + 1'b1;
endmodule

// File: rtl/wb_arbiter_2m.sv
// wb_arbiter_2m: round-robin arbiter sharing one Wishbone slave between iBus and dBus, with watchdog
module wb_arbiter_2m
  import wb_pkg::*;
#(
  parameter int ADR_W = 30,
  parameter int DAT_W = 32,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               ibus_cyc,
  input  logic               ibus_stb,
  input  logic               ibus_we,
  input  logic [ADR_W-1:0]   ibus_adr,
  input  logic [DAT_W-1:0]   ibus_dat_mosi,
  input  logic [DAT_W/8-1:0] ibus_sel,
  input  logic [2:0]         ibus_cti,
  input  logic [1:0]         ibus_bte,
  output logic               ibus_ack,
  output logic               ibus_err,
  output logic [DAT_W-1:0]   ibus_dat_miso,
  input  logic               dbus_cyc,
  input  logic               dbus_stb,
  input  logic               dbus_we,
  input  logic [ADR_W-1:0]   dbus_adr,
  input  logic [DAT_W-1:0]   dbus_dat_mosi,
  input  logic [DAT_W/8-1:0] dbus_sel,
  input  logic [2:0]         dbus_cti,
  input  logic [1:0]         dbus_bte,
  output logic               dbus_ack,
  output logic               dbus_err,
  output logic [DAT_W-1:0]   dbus_dat_miso,
  output logic               slv_cyc,
  output logic               slv_stb,
  output logic               slv_we,
  output logic [ADR_W-1:0]   slv_adr,
  output logic [DAT_W-1:0]   slv_dat_mosi,
  output logic [DAT_W/8-1:0] slv_sel,
  output logic [2:0]         slv_cti,
  output logic [1:0]         slv_bte,
  input  logic               slv_ack,
  input  logic               slv_err,
  input  logic [DAT_W-1:0]   slv_dat_miso,
  output logic [1:0]         grant,
  output logic               timeout_evt
);
  owner_t state, state_nx;
  logic last_d, gi, gd, stb_raw, fire;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= OWN_NONE;
      last_d <= 1'b1;
    end else begin
      state <= state_nx;
      if (state == OWN_I && !ibus_cyc) last_d <= 1'b0;
      else if (state == OWN_D && !dbus_cyc) last_d <= 1'b1;
    end
  // ownership lasts for the whole CYC; release hands over directly when the other master waits
  always_comb begin
    state_nx = state;
    if (state == OWN_I) state_nx = ibus_cyc ? OWN_I : dbus_cyc ? OWN_D : OWN_NONE;
    else if (state == OWN_D) state_nx = dbus_cyc ? OWN_D : ibus_cyc ? OWN_I : OWN_NONE;
    else state_nx = (ibus_cyc && (!dbus_cyc || last_d)) ? OWN_I : dbus_cyc ? OWN_D : OWN_NONE;
  end
  assign grant = state;
  assign gi = state == OWN_I;
  assign gd = state == OWN_D;
  assign slv_cyc = gi ? ibus_cyc : gd & dbus_cyc;
  assign stb_raw = gi ? ibus_stb : gd & dbus_stb;
  assign slv_stb = stb_raw & !fire;
  assign slv_we = gi ? ibus_we : gd & dbus_we;
  assign slv_adr = gi ? ibus_adr : gd ? dbus_adr : '0;
  assign slv_dat_mosi = gi ? ibus_dat_mosi : gd ? dbus_dat_mosi : '0;
  assign slv_sel = gi ? ibus_sel : gd ? dbus_sel : '0;
  assign slv_cti = gi ? ibus_cti : gd ? dbus_cti : '0;
  assign slv_bte = gi ? ibus_bte : gd ? dbus_bte : '0;
  assign ibus_ack = gi & slv_ack;
  assign dbus_ack = gd & slv_ack;
  assign ibus_err = gi & (slv_err | fire);
  assign dbus_err = gd & (slv_err | fire);
  assign ibus_dat_miso = slv_dat_miso;
  assign dbus_dat_miso = slv_dat_miso;
  assign timeout_evt = fire;
  wb_timeout_wdt #(.TIMEOUT(TIMEOUT)) u_wdt (
    .clk(clk),
    .reset_n(reset_n),
    .active(slv_cyc & stb_raw),
    .ack(slv_ack),
    .err(slv_err),
    .clear(state_nx != state),
    .fire(fire)
  );
endmodule

// File: tb/tb_wb_arbiter_2m.sv
// tb_wb_arbiter_2m: directed self-checking bench for the two-master Wishbone arbiter
module tb_wb_arbiter_2m;
  import wb_pkg::*;
  logic clk = 0, reset_n = 0;
  logic ibus_cyc = 0, ibus_stb = 0, ibus_we = 0, dbus_cyc = 0, dbus_stb = 0, dbus_we = 1;
  logic [29:0] ibus_adr = 30'h100, dbus_adr = 30'h200;
  logic [31:0] ibus_dat_mosi = 32'h1111_1111, dbus_dat_mosi = 32'h2222_2222;
  logic [3:0] ibus_sel = 4'hf, dbus_sel = 4'h3;
  logic [2:0] ibus_cti = CLASSIC, dbus_cti = CLASSIC;
  logic [1:0] ibus_bte = 0, dbus_bte = 0;
  logic ibus_ack, ibus_err, dbus_ack, dbus_err;
  logic [31:0] ibus_dat_miso, dbus_dat_miso;
  logic slv_cyc, slv_stb, slv_we;
  logic [29:0] slv_adr;
  logic [31:0] slv_dat_mosi;
  logic [3:0] slv_sel;
  logic [2:0] slv_cti;
  logic [1:0] slv_bte, grant;
  logic slv_ack = 0, slv_err = 0, timeout_evt;
  logic [31:0] slv_dat_miso = 32'hcafe_f00d;
  int checks = 0, errors = 0;

  wb_arbiter_2m #(.ADR_W(30), .DAT_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .ibus_cyc(ibus_cyc), .ibus_stb(ibus_stb), .ibus_we(ibus_we), .ibus_adr(ibus_adr),
    .ibus_dat_mosi(ibus_dat_mosi), .ibus_sel(ibus_sel), .ibus_cti(ibus_cti), .ibus_bte(ibus_bte),
    .ibus_ack(ibus_ack), .ibus_err(ibus_err), .ibus_dat_miso(ibus_dat_miso),
    .dbus_cyc(dbus_cyc), .dbus_stb(dbus_stb), .dbus_we(dbus_we), .dbus_adr(dbus_adr),
    .dbus_dat_mosi(dbus_dat_mosi), .dbus_sel(dbus_sel), .dbus_cti(dbus_cti), .dbus_bte(dbus_bte),
    .dbus_ack(dbus_ack), .dbus_err(dbus_err), .dbus_dat_miso(dbus_dat_miso),
    .slv_cyc(slv_cyc), .slv_stb(slv_stb), .slv_we(slv_we), .slv_adr(slv_adr),
    .slv_dat_mosi(slv_dat_mosi), .slv_sel(slv_sel), .slv_cti(slv_cti), .slv_bte(slv_bte),
    .slv_ack(slv_ack), .slv_err(slv_err), .slv_dat_miso(slv_dat_miso),
    .grant(grant), .timeout_evt(timeout_evt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    ibus_cyc = 1; ibus_stb = 1; dbus_cyc = 1; dbus_stb = 1; slv_ack = 1;
    #12;
    chk("rst_grant", 32'(grant), 0);
    chk("rst_slv_cyc", 32'(slv_cyc), 0);
    chk("rst_slv_stb", 32'(slv_stb), 0);
    chk("rst_acks", {30'd0, ibus_ack, dbus_ack}, 0);
    chk("rst_evt", 32'(timeout_evt), 0);
    reset_n = 1;
    tick();
    chk("first_grant_i", 32'(grant), 32'b01);
    chk("i_adr_muxed", 32'(slv_adr), 32'h100);
    chk("i_ack_fwd", {30'd0, ibus_ack, dbus_ack}, 32'b10);
    chk("i_miso", ibus_dat_miso, 32'hcafe_f00d);
    ibus_cyc = 0;
    #1;
    chk("release_cyc_low", 32'(slv_cyc), 0);
    tick();
    chk("handover_d", 32'(grant), 32'b10);
    chk("d_adr_muxed", 32'(slv_adr), 32'h200);
    chk("d_we_sel", {27'd0, slv_we, slv_sel}, 32'h13);
    // burst: ibus owns while dbus keeps requesting
    dbus_cyc = 0; ibus_cyc = 1;
    tick();
    chk("burst_grant", 32'(grant), 32'b01);
    dbus_cyc = 1;
    for (int k = 0; k < 8; k++) begin
      ibus_cti = (k == 7) ? EOB : INCR;
      ibus_adr = 30'(k);
      #1;
      chk("burst_acks", {30'd0, ibus_ack, dbus_ack}, 32'b10);
      chk("burst_cti_adr", {slv_cti, slv_adr[28:0]}, {(k == 7) ? EOB : INCR, 29'(k)});
      tick();
    end
    chk("burst_held", 32'(grant), 32'b01);
    ibus_cyc = 0; ibus_cti = CLASSIC;
    tick();
    chk("after_burst_d", {28'd0, grant, ibus_ack, dbus_ack}, 32'b1001);
    // idle, then alternate with both masters requesting continuously
    ibus_cyc = 0; dbus_cyc = 0;
    tick();
    chk("idle", 32'(grant), 0);
    ibus_cyc = 1; dbus_cyc = 1;
    tick();
    for (int t = 0; t < 10; t++) begin
      chk("alt_grant", 32'(grant), (t % 2 == 0) ? 32'b01 : 32'b10);
      if (t % 2 == 0) ibus_cyc = 0; else dbus_cyc = 0;
      tick();
      ibus_cyc = 1; dbus_cyc = 1;
    end
    ibus_cyc = 0; dbus_cyc = 0;
    tick();
    chk("idle2", 32'(grant), 0);
    // watchdog: dbus read to a silent slave
    slv_ack = 0; dbus_we = 0; dbus_cyc = 1; dbus_stb = 1; ibus_stb = 0;
    tick();
    chk("wd_grant", 32'(grant), 32'b10);
    chk("wd_stb0", {30'd0, slv_stb, dbus_err}, 32'b10);
    for (int c = 1; c < 4; c++) begin
      tick();
      chk("wd_wait", {29'd0, slv_stb, dbus_err, timeout_evt}, 32'b100);
    end
    tick();
    chk("wd_fire", {28'd0, slv_stb, dbus_err, timeout_evt, ibus_err}, 32'b0110);
    tick();
    chk("wd_after", {29'd0, slv_stb, dbus_err, timeout_evt}, 32'b100);
    for (int c = 0; c < 4; c++) tick();
    slv_ack = 1;
    #1;
    chk("ack_on_fire", {28'd0, slv_stb, dbus_ack, dbus_err, timeout_evt}, 32'b1100);
    slv_err = 1;
    #1;
    chk("ack_and_err", {30'd0, dbus_ack, dbus_err}, 32'b11);
    slv_err = 0;
    // reset asserted in the middle of an ibus burst
    ibus_cyc = 1; ibus_stb = 1; ibus_cti = INCR; dbus_cyc = 0;
    tick();
    chk("pre_rst_grant", 32'(grant), 32'b01);
    reset_n = 0;
    #1;
    chk("async_rst", {28'd0, grant, slv_cyc, ibus_ack}, 0);
    dbus_cyc = 1;
    #1;
    reset_n = 1;
    tick();
    chk("post_rst_i_first", 32'(grant), 32'b01);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
